lcd_cmd_arbiter: RTL and testbench
==================================

LCD_CMD_ARBITER -- requirements
Module: lcd_cmd_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1752, cycles the arbiter waits after each issued command before the LCD controller may accept another (50*35 + 2 margin).
REQ-002 Parameter TIMEOUT_CYCLES, default 32768, cycles a granted-pending request may see lcd_busy high before an error is flagged (timeout build only).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-requester command request; held high until the matching ack.
REQ-006 cmd0, cmd1  input  10 each  requester command {rs, rw, data[7:0]}; stable while req high.
REQ-007 ack  output  2  one-cycle per-requester completion pulse.
REQ-008 lcd_busy  input  1  busy from the downstream LCD controller.
REQ-009 lcd_enable  output  1  one-cycle command strobe to the LCD controller.
REQ-010 lcd_bus  output  10  command to the LCD controller {rs, rw, data}.
REQ-011 active  output  1  high whenever the state is not IDLE.
REQ-012 grant_id  output  1  index of the requester currently being served; holds its last value in IDLE.
REQ-013 err  output  1  sticky timeout flag.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE and HOLD.
REQ-015 IDLE: grant SHALL occur only when lcd_busy==0 and req!=0; on grant, latch the winner's cmd into lcd_bus, set grant_id, go to ISSUE.
REQ-016 Arbitration SHALL be round-robin on simultaneous requests: the requester not served last wins; a single requester wins regardless of the pointer.
REQ-017 ISSUE: lcd_enable SHALL be 1 for exactly one cycle; clear the counter; go to HOLD.
REQ-018 HOLD: count HOLD_CYCLES cycles, ignoring lcd_busy; on the terminal count pulse ack[grant_id] for one cycle and return to IDLE.
REQ-019 Grant-to-ack latency SHALL be HOLD_CYCLES+2 cycles; back-to-back commands SHALL be separated by at least one IDLE cycle.
REQ-020 lcd_bus SHALL stay constant from grant until the next grant.
REQ-021 If req drops while being served, the latched command SHALL still complete and the ack SHALL still pulse.
REQ-022 A new req arriving during ISSUE or HOLD SHALL wait; no request is ever lost.
REQ-023 The counter width SHALL be $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1) and SHALL never wrap.

Reset
REQ-024 On rst_n low, immediately set: state IDLE, lcd_enable 0, lcd_bus 0, ack 0, grant_id 0, err 0, counter 0, round-robin pointer favouring requester 0.
REQ-025 Reset asserted mid-ISSUE or mid-HOLD SHALL abort the command with no ack.

Configuration
REQ-026 Macro LCD_ARB_TIMEOUT_EN defined: in IDLE, with req!=0 and lcd_busy high continuously for TIMEOUT_CYCLES cycles, err SHALL set; it clears only on reset, and arbitration continues normally.
REQ-027 Macro LCD_ARB_TIMEOUT_EN undefined: err SHALL be tied 0, no timeout counter logic exists, and TIMEOUT_CYCLES is unused.

Structure
REQ-028 Package lcd_arb_pkg SHALL hold the state enum, the packed lcd_cmd_t {rs, rw, data[7:0]} and the default HOLD_CYCLES constant.
REQ-029 Sub-module lcd_rr_arb SHALL implement the 2-way round-robin pick: inputs req and last, output winner and valid.

Verification
REQ-030 lcd_busy=1 and req=01 for 100 cycles, then lcd_busy=0 -> grant within 1 cycle, lcd_enable pulses once, lcd_bus=cmd0, ack=01 at HOLD_CYCLES+2.
REQ-031 req=11 from reset with cmd0=0x201, cmd1=0x041 -> served 0, 1, 0, 1 alternately; lcd_bus is 0x201 then 0x041.
REQ-032 req0 dropped 10 cycles into HOLD -> ack[0] still pulses, no extra lcd_enable.
REQ-033 rst_n low mid-HOLD -> lcd_enable=0, ack=0, state IDLE, and the pending req is re-granted after release.
REQ-034 With LCD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: lcd_busy held 1 with req=10 -> err=1 at cycle 16 and stays 1 after lcd_busy falls; without the macro, err stays 0.
REQ-035 Throughout all runs: lcd_enable is never high on two consecutive cycles, and ack is never multi-bit.

Source files
------------

// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD command arbiter: FSM states,
// the {rs, rw, data} command word and the default post-command hold time.
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_cmd_t;

  // 50 * 35 controller cycles plus a 2-cycle margin
  localparam int HOLD_CYCLES_DEF = 1752;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// requester that was not served last wins.
module lcd_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  assign valid  = |req;
  assign winner = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Arbitrates two command sources onto one LCD controller with a fixed hold
// time per command. Optional busy timeout flag enabled by LCD_ARB_TIMEOUT_EN.
module lcd_cmd_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [9:0] cmd0,
  input  logic [9:0] cmd1,
  output logic [1:0] ack,
  input  logic       lcd_busy,
  output logic       lcd_enable,
  output logic [9:0] lcd_bus,
  output logic       active,
  output logic       grant_id,
  output logic       err
);

  localparam int CNT_MAX = max_int(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  lcd_cmd_t      bus_reg, bus_next;
  logic          grant_reg, grant_next;
  logic          last_reg, last_next;
  logic [1:0]    ack_reg, ack_next;
  logic [1:0]    eff_req;
  logic          arb_winner;
  logic          arb_valid;

  // The requester being acked still holds req this cycle; hide it so it is
  // not granted a second time for the same command.
  assign eff_req = req & ~ack_reg;

  lcd_rr_arb u_rr (
    .req    (eff_req),
    .last   (last_reg),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

`ifdef LCD_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic err_reg, err_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bus_reg   <= '0;
      grant_reg <= 1'b0;
      last_reg  <= 1'b1;
      ack_reg   <= 2'b00;
`ifdef LCD_ARB_TIMEOUT_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bus_reg   <= bus_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      ack_reg   <= ack_next;
`ifdef LCD_ARB_TIMEOUT_EN
      err_reg   <= err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bus_next   = bus_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    ack_next   = 2'b00;
`ifdef LCD_ARB_TIMEOUT_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
`ifdef LCD_ARB_TIMEOUT_EN
        // Counter saturates on the last timeout cycle; err is sticky.
        if (lcd_busy && (req != 2'b00)) begin
          if (cnt_reg == TIMEOUT_LAST) begin
            err_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          cnt_next = '0;
        end
`endif
        if (!lcd_busy && arb_valid) begin
          state_next = ISSUE;
          bus_next   = arb_winner ? lcd_cmd_t'(cmd1) : lcd_cmd_t'(cmd0);
          grant_next = arb_winner;
          last_next  = arb_winner;
        end
      end
      ISSUE: begin
        state_next = HOLD;
        cnt_next   = '0;
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          ack_next   = grant_reg ? 2'b10 : 2'b01;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign lcd_enable = (state_reg == ISSUE);
  assign active     = (state_reg != IDLE);
  assign lcd_bus    = bus_reg;
  assign grant_id   = grant_reg;
  assign ack        = ack_reg;

`ifdef LCD_ARB_TIMEOUT_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter: busy gating, round-robin order,
// request drop, mid-command reset and the optional busy timeout.
module tb_lcd_cmd_arbiter;

  localparam int H       = 24;
  localparam int TO      = 16;
  localparam int BUDGET  = H + 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [9:0] cmd0 = 10'h000;
  logic [9:0] cmd1 = 10'h000;
  logic [1:0] ack;
  logic       lcd_busy = 1'b0;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       active;
  logic       grant_id;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;
  logic prev_en = 1'b0;

  lcd_cmd_arbiter #(.HOLD_CYCLES(H), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .cmd0       (cmd0),
    .cmd1       (cmd1),
    .ack        (ack),
    .lcd_busy   (lcd_busy),
    .lcd_enable (lcd_enable),
    .lcd_bus    (lcd_bus),
    .active     (active),
    .grant_id   (grant_id),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle invariants: single-cycle strobe, one-hot-or-zero ack
  always @(negedge clk) begin
    check("en_not_consecutive", {31'b0, lcd_enable & prev_en}, 32'd0);
    check("ack_not_multibit", {31'b0, ack == 2'b11}, 32'd0);
    prev_en = lcd_enable;
    if (lcd_enable) en_count++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_en(input string tag);
    int n;
    n = 0;
    while (!lcd_enable && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, lcd_enable}, 32'd1);
  endtask

  task automatic wait_ack(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack == 2'b00 && lat < BUDGET);
    check(tag, {31'b0, ack != 2'b00}, 32'd1);
  endtask

  initial begin
    int lat;
    int en_pre;
    int en_mid;
    logic [9:0] exp_bus;
    logic       exp_err;

`ifdef LCD_ARB_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_active", {31'b0, active}, 32'd0);
    check("rst_enable", {31'b0, lcd_enable}, 32'd0);
    check("rst_bus", {22'b0, lcd_bus}, 32'd0);
    check("rst_ack", {30'b0, ack}, 32'd0);
    check("rst_grant", {31'b0, grant_id}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Busy gating, then latency of H+2 from the granting cycle
    cmd0 = 10'h2A5;
    lcd_busy = 1'b1;
    req = 2'b01;
    repeat (100) @(negedge clk);
    check("busy_no_grant", {31'b0, active}, 32'd0);
    en_pre = en_count;
    lcd_busy = 1'b0;
    @(negedge clk);
    check("a_enable", {31'b0, lcd_enable}, 32'd1);
    check("a_grant", {31'b0, grant_id}, 32'd0);
    check("a_bus", {22'b0, lcd_bus}, 32'h2A5);
    wait_ack("a_ack_seen", lat);
    check("a_latency", lat + 1, H + 2);
    check("a_ack", {30'b0, ack}, 32'd1);
    check("a_bus_hold", {22'b0, lcd_bus}, 32'h2A5);
    check("a_en_once", en_count - en_pre, 32'd1);
    $display("txn: requester 0 cmd 0x%0h acked after %0d cycles", lcd_bus, lat + 1);
    req = 2'b00;
    @(negedge clk);
    check("a_idle_after", {31'b0, active}, 32'd0);
    check("a_ack_cleared", {30'b0, ack}, 32'd0);

    // Round-robin on a permanent tie
    cmd0 = 10'h201;
    cmd1 = 10'h041;
    req = 2'b11;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_bus = (i % 2 == 0) ? 10'h201 : 10'h041;
      wait_en("rr_en");
      check("rr_grant", {31'b0, grant_id}, i % 2);
      check("rr_bus", {22'b0, lcd_bus}, {22'b0, exp_bus});
      wait_ack("rr_ack_seen", lat);
      check("rr_ack", {30'b0, ack}, (i % 2 == 0) ? 32'd1 : 32'd2);
      $display("txn: rr %0d requester %0d cmd 0x%0h ack %b", i, grant_id, lcd_bus, ack);
    end

    // Request dropped during HOLD still completes
    req = 2'b01;
    cmd0 = 10'h155;
    do_reset();
    en_pre = en_count;
    wait_en("drop_en");
    repeat (10) @(negedge clk);
    en_mid = en_count;
    req = 2'b00;
    wait_ack("drop_ack_seen", lat);
    check("drop_ack", {30'b0, ack}, 32'd1);
    check("drop_en_once", en_count - en_pre, 32'd1);
    repeat (3) @(negedge clk);
    check("drop_idle", {31'b0, active}, 32'd0);
    check("drop_no_extra_en", en_count - en_mid, 32'd0);
    $display("txn: dropped request 0 cmd 0x155 acked");

    // Reset in the middle of HOLD aborts; pending request re-granted
    req = 2'b10;
    cmd1 = 10'h0C3;
    do_reset();
    wait_en("mid_en");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_enable", {31'b0, lcd_enable}, 32'd0);
    check("mid_rst_ack", {30'b0, ack}, 32'd0);
    check("mid_rst_active", {31'b0, active}, 32'd0);
    check("mid_rst_grant", {31'b0, grant_id}, 32'd0);
    check("mid_rst_bus", {22'b0, lcd_bus}, 32'd0);
    @(negedge clk);
    check("mid_rst_hold_ack", {30'b0, ack}, 32'd0);
    rst_n = 1'b1;
    wait_en("regrant_en");
    check("regrant_id", {31'b0, grant_id}, 32'd1);
    check("regrant_bus", {22'b0, lcd_bus}, 32'h0C3);
    wait_ack("regrant_ack_seen", lat);
    check("regrant_ack", {30'b0, ack}, 32'd2);
    $display("txn: requester 1 cmd 0x0C3 re-granted after reset, ack %b", ack);
    req = 2'b00;

    // Busy timeout (sticky when enabled, always 0 otherwise)
    lcd_busy = 1'b1;
    req = 2'b10;
    do_reset();
    repeat (TO - 1) @(negedge clk);
    check("to_before", {31'b0, err}, 32'd0);
    @(negedge clk);
    check("to_at", {31'b0, err}, {31'b0, exp_err});
    lcd_busy = 1'b0;
    wait_en("to_en");
    check("to_sticky", {31'b0, err}, {31'b0, exp_err});
    wait_ack("to_ack_seen", lat);
    check("to_ack", {30'b0, ack}, 32'd2);
    check("to_sticky_end", {31'b0, err}, {31'b0, exp_err});
    $display("txn: requester 1 served after busy stall, err %b", err);
    req = 2'b00;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
